// File: rtl/dram_bus_responder.sv
// Memory-side end of the arbitrated DRAM bus: turns each request into single-word
// req/ack backend transactions with lane steering, load extension and a watchdog.
module dram_bus_responder #(
   parameter int          ADDR_W   = 32,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic [ADDR_W-1:0] w_dram_addr,
   input  logic [31:0]       w_dram_wdata,
   input  logic              w_dram_we_t,
   input  logic              w_dram_le,
   input  logic [2:0]        w_dram_ctrl,
   output logic              w_dram_busy,
   output logic [31:0]       w_dram_odata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]        state;
   logic              shadow;
   logic              pend_rd;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        ctrl_q;
   logic              start_wr;
   logic              start_rd;

   function automatic logic access_ok(input logic [2:0] ctrl, input logic [1:0] a);
      case (ctrl)
         3'd0, 3'd4: access_ok = 1'b1;
         3'd1, 3'd5: access_ok = ~a[0];
         3'd2:       access_ok = (a == 2'd0);
         default:    access_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] a);
      case (ctrl[1:0])
         2'd0:    lane_be = 4'b0001 << a;
         2'd1:    lane_be = 4'b0011 << a;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] ctrl, input logic [31:0] d);
      case (ctrl[1:0])
         2'd0:    lane_wdata = {4{d[7:0]}};
         2'd1:    lane_wdata = {2{d[15:0]}};
         default: lane_wdata = d;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] ctrl, input logic [1:0] a,
                                            input logic [31:0] word);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] ext;
      sb = word[{a, 3'b000} +: 8];
      sh = word[{a[1], 4'b0000} +: 16];
      case (ctrl)
         3'd0:    ext = sb;
         3'd1:    ext = sh;
         3'd4:    ext = {24'd0, sb};
         3'd5:    ext = {16'd0, sh};
         default: ext = word;
      endcase
      load_ext = ext;
   endfunction

   assign start_wr    = (state == S_IDLE) && (w_dram_we_t != shadow);
   assign start_rd    = (state == S_IDLE) && w_dram_le;
   assign w_dram_busy = (state != S_IDLE) | start_wr | start_rd;

   assign mem_req   = (state == S_WR) || (state == S_RD);
   assign mem_we    = (state == S_WR);
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = lane_wdata(ctrl_q, wdata_q);
   assign mem_be    = mem_req ? lane_be(ctrl_q, addr_q[1:0]) : 4'b0000;

   // Request capture: the backend only ever sees these latched copies
   always_ff @(posedge CLK) begin
      if (start_wr || start_rd) begin
         addr_q  <= w_dram_addr;
         wdata_q <= w_dram_wdata;
         ctrl_q  <= w_dram_ctrl;
      end
   end

   always_ff @(posedge CLK or posedge RST_X) begin
      if (RST_X) begin
         state        <= S_IDLE;
         shadow       <= 1'b0;
         pend_rd      <= 1'b0;
         cnt          <= 8'd0;
         w_dram_odata <= 32'd0;
         err          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               shadow <= w_dram_we_t;
               cnt    <= 8'd0;
               if (start_wr || start_rd) begin
                  if (!access_ok(w_dram_ctrl, w_dram_addr[1:0])) begin
                     err     <= 1'b1;
                     pend_rd <= 1'b0;
                     state   <= S_DONE;
                     if (start_rd) w_dram_odata <= ERR_DATA;
                  end else if (start_wr) begin
                     pend_rd <= start_rd;
                     state   <= S_WR;
                  end else begin
                     state <= S_RD;
                  end
               end
            end
            S_WR: begin
               if (mem_ack) begin
                  cnt     <= 8'd0;
                  pend_rd <= 1'b0;
                  state   <= pend_rd ? S_RD : S_DONE;
               end else if (cnt == TO_LAST) begin
                  // A read queued behind a dead write can never run
                  err     <= 1'b1;
                  pend_rd <= 1'b0;
                  state   <= S_DONE;
                  if (pend_rd) w_dram_odata <= ERR_DATA;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_RD: begin
               if (mem_ack) begin
                  w_dram_odata <= load_ext(ctrl_q, addr_q[1:0], mem_rdata);
                  state        <= S_DONE;
               end else if (cnt == TO_LAST) begin
                  err          <= 1'b1;
                  w_dram_odata <= ERR_DATA;
                  state        <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_bus_responder.sv
// Scoreboard bench for dram_bus_responder: a small word memory answers the backend port,
// expected writes and load results are queued at stimulus time and compared on completion.
module tb_dram_bus_responder;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   logic        CLK = 1'b0;
   logic        RST_X;
   logic [31:0] w_dram_addr;
   logic [31:0] w_dram_wdata;
   logic        w_dram_we_t;
   logic        w_dram_le;
   logic [2:0]  w_dram_ctrl;
   logic        w_dram_busy;
   logic [31:0] w_dram_odata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        err;

   logic [31:0] mem [0:1023];
   logic        ack_en;
   int          req_cyc;
   int          n_chk  = 0;
   int          n_pass = 0;
   wr_t         wq[$];
   logic [31:0] rq[$];

   always #5 CLK = ~CLK;

   assign mem_ack   = mem_req & ack_en;
   assign mem_rdata = mem[mem_addr[11:2]];

   dram_bus_responder #(.ADDR_W(32), .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_we_t(w_dram_we_t),
      .w_dram_le(w_dram_le), .w_dram_ctrl(w_dram_ctrl), .w_dram_busy(w_dram_busy),
      .w_dram_odata(w_dram_odata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .err(err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // Backend model: applies acked writes and checks them against the expected queue
   always @(negedge CLK) begin
      if (mem_req) req_cyc++;
      if (mem_req && mem_we && mem_ack) begin
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) mem[mem_addr[11:2]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
         if (wq.size() == 0) begin
            check("wr_unexpected", mem_addr, 32'hFFFFFFFF);
         end else begin
            wr_t e;
            e = wq.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_be", {28'd0, mem_be}, {28'd0, e.be});
            check("wr_data", mem_wdata, e.data);
         end
      end
   end

   task automatic do_reset();
      w_dram_we_t = 1'b0;
      w_dram_le   = 1'b0;
      RST_X       = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST_X = 1'b0;
   endtask

   task automatic do_req(input string tag, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data, input logic [2:0] ctrl,
                         input int exp_busy, input int exp_req);
      int busy_n;
      int cyc;
      @(posedge CLK);
      #1;
      req_cyc      = 0;
      w_dram_addr  = addr;
      w_dram_wdata = data;
      w_dram_ctrl  = ctrl;
      if (wr) w_dram_we_t = ~w_dram_we_t;
      w_dram_le = rd;
      busy_n = 0;
      cyc    = 0;
      while (cyc < 50) begin
         @(negedge CLK);
         if (!w_dram_busy) break;
         busy_n++;
         @(posedge CLK);
         #1 w_dram_le = 1'b0;
         cyc++;
      end
      w_dram_le = 1'b0;
      check({tag, "_busy"}, busy_n, exp_busy);
      check({tag, "_req"}, req_cyc, exp_req);
      if (rd) begin
         if (rq.size() == 0) check({tag, "_noexp"}, w_dram_odata, 32'hFFFFFFFF);
         else check({tag, "_odata"}, w_dram_odata, rq.pop_front());
      end
   endtask

   task automatic push_wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
      wr_t e;
      e.addr = addr;
      e.be   = be;
      e.data = data;
      wq.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[32'h200 >> 2] = 32'h80FF7F01;
      ack_en       = 1'b1;
      req_cyc      = 0;
      w_dram_addr  = 32'd0;
      w_dram_wdata = 32'd0;
      w_dram_ctrl  = 3'd2;
      do_reset();
      #1;
      check("rst_busy", {31'd0, w_dram_busy}, 32'd0);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_odata", w_dram_odata, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      push_wr(32'h100, 4'hF, 32'h11223344);
      do_req("sw", 1'b1, 1'b0, 32'h100, 32'h11223344, 3'd2, 3, 1);
      rq.push_back(32'h11223344);
      do_req("lw", 1'b0, 1'b1, 32'h100, 32'h0, 3'd2, 3, 1);

      rq.push_back(32'hFFFFFF80);
      do_req("lb", 1'b0, 1'b1, 32'h203, 32'h0, 3'd0, 3, 1);
      rq.push_back(32'h00000080);
      do_req("lbu", 1'b0, 1'b1, 32'h203, 32'h0, 3'd4, 3, 1);
      rq.push_back(32'hFFFF80FF);
      do_req("lh", 1'b0, 1'b1, 32'h202, 32'h0, 3'd1, 3, 1);
      rq.push_back(32'h00007F01);
      do_req("lhu", 1'b0, 1'b1, 32'h200, 32'h0, 3'd5, 3, 1);

      push_wr(32'h300, 4'b0010, 32'hABABABAB);
      do_req("sb", 1'b1, 1'b0, 32'h301, 32'h123456AB, 3'd0, 3, 1);
      push_wr(32'h300, 4'b1100, 32'hBEEFBEEF);
      do_req("sh", 1'b1, 1'b0, 32'h302, 32'h0000BEEF, 3'd1, 3, 1);
      rq.push_back(32'hBEEFAB00);
      do_req("lw300", 1'b0, 1'b1, 32'h300, 32'h0, 3'd2, 3, 1);

      push_wr(32'h400, 4'hF, 32'hCAFEF00D);
      rq.push_back(32'hCAFEF00D);
      do_req("wr_rd", 1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 3'd2, 4, 2);
      check("err_clean", {31'd0, err}, 32'd0);

      rq.push_back(32'hDEADBEEF);
      do_req("lw_mis", 1'b0, 1'b1, 32'h502, 32'h0, 3'd2, 2, 0);
      check("err_mis", {31'd0, err}, 32'd1);
      do_req("sh_mis", 1'b1, 1'b0, 32'h301, 32'h1234, 3'd1, 2, 0);
      rq.push_back(32'hDEADBEEF);
      do_req("ill_ctrl", 1'b0, 1'b1, 32'h100, 32'h0, 3'd3, 2, 0);

      do_reset();
      #1 check("err_rst", {31'd0, err}, 32'd0);
      ack_en = 1'b0;
      rq.push_back(32'hDEADBEEF);
      do_req("to_rd", 1'b0, 1'b1, 32'h100, 32'h0, 3'd2, 6, 4);
      check("err_to", {31'd0, err}, 32'd1);

      // Reset while the read is stalled in the backend phase
      @(posedge CLK);
      #1;
      w_dram_addr = 32'h100;
      w_dram_ctrl = 3'd2;
      w_dram_le   = 1'b1;
      @(posedge CLK);
      #1 w_dram_le = 1'b0;
      @(posedge CLK);
      #1 check("pre_rst_req", {31'd0, mem_req}, 32'd1);
      #2 RST_X = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, mem_req}, 32'd0);
      check("mid_rst_busy", {31'd0, w_dram_busy}, 32'd0);
      check("mid_rst_odata", w_dram_odata, 32'd0);
      @(posedge CLK);
      #1 RST_X = 1'b0;
      ack_en = 1'b1;
      @(negedge CLK);
      check("post_rst_busy", {31'd0, w_dram_busy}, 32'd0);
      rq.push_back(32'h11223344);
      do_req("lw_after", 1'b0, 1'b1, 32'h100, 32'h0, 3'd2, 3, 1);

      check("wq_left", wq.size(), 32'd0);
      check("rq_left", rq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dram_bus_responder.md
Name: dram_bus_responder

Overview:
- Memory-side end of the shared DRAM bus driven by the core bus arbiter.
- Accepts the arbitrated request (address, write data, write toggle, load enable, access control) and drives busy and read data back to the arbiter.
- Translates each request into single-word transactions on a req/ack backend memory port, with byte-enable generation, load extraction/extension and a timeout watchdog.

Parameters:
- ADDR_W, 32, width of the DRAM byte address
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (8-bit counter; 1..255)
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
- CLK  in  1  system clock
- RST_X  in  1  reset; asynchronous, active-high
- w_dram_addr  in  ADDR_W  byte address of the request
- w_dram_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- w_dram_we_t  in  1  write toggle; any change versus the last sampled value starts one write
- w_dram_le  in  1  load enable; one-cycle pulse starts one read
- w_dram_ctrl  in  3  access type in RISC-V funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU
- w_dram_busy  out  1  request in progress
- w_dram_odata  out  32  load result; held until the next read completes
- mem_req  out  1  backend request, held until ack
- mem_we  out  1  backend write
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] = 0)
- mem_wdata  out  32  lane-positioned store data
- mem_be  out  4  byte enables
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  backend read word
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset values: all registered outputs 0; state IDLE; we_t shadow register 0; no pending read.
- Request detect in IDLE:
  - start_wr = (w_dram_we_t != shadow)
  - start_rd = w_dram_le
  - shadow updates every cycle in IDLE only. Toggles while not IDLE are not tracked; they are detected on return to IDLE.
- w_dram_busy = (state != IDLE) | start_wr | start_rd. It is combinational, so busy rises in the same cycle the request appears.
- Capture on start: addr, wdata and ctrl are latched. The backend only ever sees latched values.
- Simultaneous start_wr and start_rd: the write executes first, then the read, using the same latched addr and ctrl. Busy stays high throughout.
- FSM:
  - IDLE -> WR on start_wr; IDLE -> RD on start_rd only.
  - WR and RD: mem_req = 1 until mem_ack.
  - WR -> RD on ack when a read is pending; otherwise WR -> DONE.
  - RD -> DONE on ack.
  - DONE -> IDLE after one cycle; busy is high in DONE.
- Minimum request latency with same-cycle ack: 3 cycles busy (WR/RD, DONE, then IDLE).
- Write lanes (a = addr[1:0]):
  - B: be = 1 << a, data replicated to all four bytes.
  - H: be = 4'b0011 << a, data replicated to both halves.
  - W: be = 4'b1111, data unmodified.
- Read extraction: byte/half selected by a, then sign-extended (B/H) or zero-extended (BU/HU). w_dram_odata updates on the ack cycle edge.
- Misaligned or illegal requests:
  - Covers H/HU with a[0] = 1, W with a != 0, and ctrl values 3, 6, 7.
  - No backend access is made; err is set.
  - A read returns ERR_DATA; a write is dropped.
  - Both still pass through DONE, so busy is 2 cycles.
- Timeout:
  - Counter clears on entering WR or RD and increments each cycle without ack.
  - When it reaches TIMEOUT: drop mem_req, set err, go to DONE, and discard any pending read.
  - If the timed-out phase is RD, or a read was pending, odata = ERR_DATA.
- Reset mid-operation: mem_req drops immediately, pending read is discarded, odata is cleared.

Test Plan:
- Aligned word: write 0x11223344 to 0x100 (toggle we_t) -> mem_be = F, mem_addr = 0x100, busy high 3 cycles with ack on the first req cycle. Then pulse le with ctrl = 2 -> odata = 0x11223344.
- Byte/half loads: backend word 0x80FF7F01 at 0x200.
  - LB at 0x203 -> 0xFFFFFF80.
  - LBU at 0x203 -> 0x00000080.
  - LH at 0x202 -> 0xFFFF80FF.
  - LHU at 0x200 -> 0x00007F01.
- Sub-word store: SB 0xAB at 0x301 -> mem_be = 4'b0010, mem_wdata = 0xABABABAB. SH 0xBEEF at 0x302 -> mem_be = 4'b1100.
- Simultaneous: we_t toggle and le in the same cycle at 0x400, ctrl W, data 0xCAFEF00D -> write transaction, then read transaction, busy continuous, odata = 0xCAFEF00D.
- Error paths:
  - LW at 0x502 -> no mem_req, err = 1, odata = 0xDEADBEEF, busy 2 cycles.
  - With TIMEOUT = 4 and ack held low, a read -> mem_req drops after 4 cycles, err = 1, odata = ERR_DATA.
- Reset mid-read: assert RST_X while in RD -> mem_req = 0 and busy = 0 in the same cycle, odata = 0, state IDLE after release.
